aes_block_loader: RTL and testbench
===================================

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LATENCY, 21, clock edges from the core sampling state/key to the core result being valid on core_out.
- OUT_DEPTH, 4, output FIFO entries; also the credit limit; range 1..15.

REQ-002 Clocking and reset: one clock; reset is synchronous and active-high; the ports are named clk and rst.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- key_in  in  128  new cipher key.
- key_load  in  1  capture key_in into the key register.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  32  plaintext word, first word is most significant.
- core_state  out  128  plaintext block to the core.
- core_key  out  128  key to the core.
- core_out  in  128  ciphertext from the core; no handshake.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer pop; a pop occurs when out_valid && out_ready.
- out_data  out  128  ciphertext at the FIFO head.
- inflight  out  5  number of blocks issued and not yet captured.
- err_ovf  out  1  sticky: a capture occurred while the FIFO was full.

Function
REQ-004 FSM SHALL have two states, FILL and HOLD, with in_ready = (state==FILL).
REQ-005 In FILL, each accepted word SHALL be written to the assembly register at slot word_cnt.
- word 0 goes to [127:96], word 3 goes to [31:0].
- word_cnt increments 0..3.
REQ-006 Accepting word 3 SHALL move the FSM to HOLD and wrap word_cnt to 0.
REQ-007 credit_ok SHALL be (inflight + fifo_count) < OUT_DEPTH.
REQ-008 In HOLD with credit_ok=1, the block SHALL issue on that edge:
- token shift-register bit 0 is set;
- inflight increments;
- the FSM returns to FILL.
REQ-009 In HOLD with credit_ok=0, the FSM SHALL stay in HOLD with core_state stable.
REQ-010 core_state SHALL equal the assembly register at all times, and core_key SHALL equal the key register; the core samples both on the issue edge.
REQ-011 Sustained throughput SHALL be one block per 5 cycles (4 FILL cycles plus 1 HOLD cycle).
REQ-012 The token shift register SHALL be LATENCY bits wide and shift by one position every cycle.
REQ-013 When bit LATENCY-1 is set, the block SHALL capture core_out into the FIFO tail on that edge, so a block issued at edge E is captured at edge E+LATENCY; the capture also decrements inflight.
REQ-014 An issue and a capture on the same edge SHALL leave inflight unchanged.
REQ-015 The FIFO SHALL be a first-word-fall-through structure:
- out_valid = (fifo_count != 0);
- out_data = head entry;
- a pop advances the head.
REQ-016 A push and a pop on the same edge SHALL leave fifo_count unchanged; read and write pointers wrap modulo OUT_DEPTH.
REQ-017 A capture with fifo_count == OUT_DEPTH and no simultaneous pop SHALL set err_ovf and drop the capture; this is unreachable while REQ-007 holds.
REQ-018 key_load SHALL update the key register on any edge.
- If key_load coincides with an issue, the issued block uses the old key.
- Later issues use the new key.
REQ-019 Ciphertext order SHALL equal plaintext order; blocks SHALL NOT be reordered or duplicated.
REQ-020 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-021 rst=1 on an edge SHALL force all of the following, regardless of other inputs:
- state=FILL, word_cnt=0, in_ready=1;
- tokens=0, inflight=0;
- fifo_count=0, out_valid=0, err_ovf=0;
- assembly register=0, key register=0 (so core_state=0, core_key=0).
REQ-022 A reset mid-operation SHALL discard the partial block, all in-flight tokens and all FIFO contents.
- core_out results from pre-reset issues are never captured.
REQ-023 While rst=1, the block SHALL accept no words and perform no issues, captures or pops.

Verification
REQ-024 FIPS-197 vector with the real core attached, default parameters:
- load key 000102030405060708090a0b0c0d0e0f;
- stream words 00112233, 44556677, 8899aabb, ccddeeff;
- required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid rising 21 edges after the issue edge.
REQ-025 Backpressure, OUT_DEPTH=4, out_ready=0, 6 blocks streamed:
- the first 4 blocks issue;
- the 5th block waits in HOLD with in_ready=0 and inflight+fifo_count=4;
- err_ovf stays 0.
REQ-026 Backpressure release for the REQ-025 setup:
- raise out_ready for 1 cycle;
- required: exactly one pop, then the 5th block issues on the next edge.
REQ-027 Ordering under random stalls:
- 50 blocks, random in_valid, random out_ready, core replaced by a LATENCY-deep delay model returning state^key;
- required: all 50 results in order, none lost, err_ovf=0.
REQ-028 Key switch:
- key_load asserted with a new key on the issue edge of block 1;
- required: block 1 ciphertext is computed with the old key, block 2 with the new key.
REQ-029 Reset mid-flight:
- assert rst for 1 cycle with 3 blocks in flight and 2 words of a partial block assembled;
- required: out_valid stays 0 for 30 cycles, inflight=0, in_ready=1;
- the next 4 words produce exactly one correct result.

Source files
------------

// File: rtl/aes_block_loader.sv
// Feeds 32-bit plaintext words to a fixed-latency AES core as 128-bit blocks and
// collects ciphertext into a credit-protected FWFT FIFO.
module aes_block_loader #(
    parameter int unsigned LATENCY   = 21,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [4:0]   inflight,
    output logic         err_ovf
);

    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = 5;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_word_cnt;
    logic [127:0]     r_asm;
    logic [127:0]     r_key;
    logic [LATENCY-1:0] r_tok;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [127:0]     r_fifo [OUT_DEPTH];
    logic             r_err_ovf;

    logic w_accept;
    logic w_issue;
    logic w_credit_ok;
    logic w_capture;
    logic w_pop;
    logic w_push;
    logic w_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers both in-flight blocks and queued results, so the FIFO can never overflow.
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < 6'(OUT_DEPTH);
    assign w_capture   = r_tok[LATENCY-1];
    assign w_full      = (r_count == CW'(OUT_DEPTH));
    assign w_pop       = out_valid && out_ready;
    assign w_push      = w_capture && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_FILL: begin
                w_accept = in_valid;
                if (in_valid && (r_word_cnt == 2'd3)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_credit_ok) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Block assembly (word 0 lands in the top slice) and key register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= 2'd0;
            r_asm      <= '0;
            r_key      <= '0;
        end else begin
            if (w_accept) begin
                case (r_word_cnt)
                    2'd0:    r_asm[127:96] <= in_data;
                    2'd1:    r_asm[95:64]  <= in_data;
                    2'd2:    r_asm[63:32]  <= in_data;
                    default: r_asm[31:0]   <= in_data;
                endcase
                r_word_cnt <= r_word_cnt + 2'd1;
            end
            if (key_load) begin
                r_key <= key_in;
            end
        end
    end

    // Token pipeline mirrors the core latency; the last bit marks the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tok      <= '0;
            r_inflight <= '0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_tok <= {r_tok[LATENCY-2:0], w_issue};
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (w_capture && w_full && !w_pop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= core_out;
        end
    end

    assign in_ready   = (r_state == S_FILL);
    assign core_state = r_asm;
    assign core_key   = r_key;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_fifo[r_rd_ptr];
    assign inflight   = r_inflight;
    assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench: transaction-level queue model of the loader plus a
// fixed-latency core stand-in; directed scenarios plus randomized streaming.
module tb_aes_block_loader;

    localparam int unsigned LAT   = 21;
    localparam int unsigned DEPTH = 4;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   inflight;
    logic         err_ovf;

    aes_block_loader #(.LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .inflight(inflight), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Core stand-in: the FIPS-197 vector is answered exactly, anything else returns state^key.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return s ^ k;
    endfunction

    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= core_f(core_state, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 25) $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: blocks in flight carry their issue edge and expected result.
    typedef struct {
        int           t;
        logic [127:0] v;
    } fl_t;

    fl_t          m_fl[$];
    logic [127:0] m_fifo[$];
    int           m_words = 0;
    logic [127:0] m_asm = '0;
    logic [127:0] m_key = '0;
    logic         m_err = 1'b0;
    int           cyc = 0;
    bit           mp, mc, mi;
    fl_t          me;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_fl.delete();
            m_fifo.delete();
            m_words = 0;
            m_asm   = '0;
            m_key   = '0;
            m_err   = 1'b0;
        end else begin
            mp = (m_fifo.size() != 0) && out_ready;
            mc = (m_fl.size() != 0) && (m_fl[0].t + LAT == cyc);
            mi = (m_words == 4) && (m_fl.size() + m_fifo.size() < DEPTH);
            if (mi) begin
                me.t = cyc;
                me.v = core_f(m_asm, m_key);
                m_fl.push_back(me);
                m_words = 0;
            end else if (m_words < 4 && in_valid) begin
                m_asm[127 - 32*m_words -: 32] = in_data;
                m_words++;
            end
            if (mp) void'(m_fifo.pop_front());
            if (mc) begin
                me = m_fl.pop_front();
                if (m_fifo.size() < DEPTH) m_fifo.push_back(me.v);
                else m_err = 1'b1;
            end
            if (key_load) m_key = key_in;
        end
    end

    bit           chk_en = 1'b0;
    logic [127:0] popped[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 128'(in_ready), 128'(m_words < 4));
            chk("out_valid", 128'(out_valid), 128'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) chk("out_data", out_data, m_fifo[0]);
            chk("inflight", 128'(inflight), 128'(m_fl.size()));
            chk("core_state", core_state, m_asm);
            chk("core_key", core_key, m_key);
            chk("err_ovf", 128'(err_ovf), 128'(m_err));
            if (!rst && out_valid && out_ready) popped.push_back(out_data);
        end
    end

    bit rnd_rdy = 1'b0;
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = 1'($urandom_range(1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int pct);
        bit acc;
        int b;
        acc = 1'b0;
        b = 0;
        while (!acc) begin
            in_valid = (int'($urandom_range(99)) < pct);
            in_data  = w;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            b++;
            if (!acc && b > 3000) begin
                checks++;
                fails++;
                $display("FAIL send_word_timeout act=%0d cycles exp=accept", b);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input int pct);
        for (int i = 0; i < 4; i++) send_word(blk[127 - 32*i -: 32], pct);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((m_fl.size() != 0 || m_fifo.size() != 0 || m_words != 0) && b < 3000) begin
            tick(1);
            b++;
        end
        if (b >= 3000) begin
            checks++;
            fails++;
            $display("FAIL wait_idle_timeout act=%0d cycles exp=drained", b);
        end
    endtask

    function automatic logic [127:0] bp_blk(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=%0t exp=finish", $time);
        $fatal(1);
    end

    logic [127:0] exp_q[$];
    logic [127:0] rk, blk, ka, kb;
    int           t_iss, t_ov, n0;
    bit           done_bp;

    initial begin
        tick(2);
        chk_en = 1'b1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_inflight", 128'(inflight), 128'(0));
        chk("rst_core_state", core_state, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_err_ovf", 128'(err_ovf), 128'(0));
        rst = 1'b0;
        tick(1);

        // FIPS-197 vector and issue-to-valid latency.
        key_in = FIPS_KEY;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        send_block(FIPS_PT, 100);
        t_iss = -1;
        t_ov = -1;
        for (int i = 0; i < 100 && t_ov < 0; i++) begin
            @(negedge clk);
            if (t_iss < 0 && inflight == 5'd1) t_iss = cyc;
            if (t_ov < 0 && out_valid) t_ov = cyc;
        end
        chk("fips_latency", 128'(t_ov - t_iss), 128'(21));
        chk("fips_ct", out_data, FIPS_CT);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // Backpressure: four blocks fill the credit, fifth parks in HOLD.
        out_ready = 1'b0;
        done_bp = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_block(bp_blk(i), 100);
                done_bp = 1'b1;
            end
        join_none
        tick(60);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_inflight", 128'(inflight), 128'(0));
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        chk("bp_err_ovf", 128'(err_ovf), 128'(0));
        chk("bp_head", out_data, bp_blk(0) ^ FIPS_KEY);
        n0 = popped.size();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("bp_one_pop", 128'(popped.size() - n0), 128'(1));
        chk("bp_still_hold", 128'(in_ready), 128'(0));
        chk("bp_head2", out_data, bp_blk(1) ^ FIPS_KEY);
        tick(1);
        chk("bp_issue_inflight", 128'(inflight), 128'(1));
        chk("bp_issue_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 500 && !done_bp; i++) tick(1);
        chk("bp_stream_done", 128'(done_bp), 128'(1));
        wait_idle();

        // Randomized streaming with random consumer stalls.
        rk = {$urandom, $urandom, $urandom, $urandom};
        key_in = rk;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        n0 = popped.size();
        exp_q.delete();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(blk ^ rk);
            send_block(blk, 60);
        end
        rnd_rdy = 1'b0;
        tick(1);
        out_ready = 1'b1;
        wait_idle();
        chk("rnd_count", 128'(popped.size() - n0), 128'(50));
        for (int i = 0; i < 50 && n0 + i < popped.size(); i++) chk("rnd_order", popped[n0 + i], exp_q[i]);
        chk("rnd_err_ovf", 128'(err_ovf), 128'(0));

        // Key switch on the issue edge of block 1.
        ka = 128'hA5A5A5A5_00000000_FFFFFFFF_12345678;
        kb = 128'h0F0F0F0F_F0F0F0F0_DEADBEEF_CAFEF00D;
        key_in = ka;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        n0 = popped.size();
        send_block(128'h11111111_22222222_33333333_44444444, 100);
        key_in = kb;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        send_block(128'h55555555_66666666_77777777_88888888, 100);
        wait_idle();
        chk("key_cnt", 128'(popped.size() - n0), 128'(2));
        if (popped.size() >= n0 + 2) begin
            chk("key_old", popped[n0], 128'h11111111_22222222_33333333_44444444 ^ ka);
            chk("key_new", popped[n0 + 1], 128'h55555555_66666666_77777777_88888888 ^ kb);
        end

        // Reset mid-flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_block(bp_blk(10 + i), 100);
        send_word(32'hAAAA0001, 100);
        send_word(32'hAAAA0002, 100);
        chk("rstm_inflight_pre", 128'(inflight), 128'(3));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstm_inflight", 128'(inflight), 128'(0));
        chk("rstm_in_ready", 128'(in_ready), 128'(1));
        chk("rstm_core_state", core_state, 128'(0));
        chk("rstm_core_key", core_key, 128'(0));
        for (int i = 0; i < 30; i++) begin
            chk("rstm_out_valid", 128'(out_valid), 128'(0));
            tick(1);
        end
        out_ready = 1'b1;
        n0 = popped.size();
        send_block(128'h01234567_89ABCDEF_FEDCBA98_76543210, 100);
        wait_idle();
        chk("rstm_cnt", 128'(popped.size() - n0), 128'(1));
        if (popped.size() > n0) chk("rstm_val", popped[n0], 128'h01234567_89ABCDEF_FEDCBA98_76543210);

        tick(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
